spi_target: RTL
===============

# spi_target

Mode-0 SPI target (peripheral side) that oversamples the SPI pins on the system clock and exchanges bytes with a host such as `spictrl`. Received bytes go to a register-style read interface; bytes to return are staged in a one-byte TX holding register. Used to bench-test and loop back the SD/flash SPI master, and as a slave port for an external controller.

## Interface
Parameters:
- `IDLE_BYTE`, 8'hFF, shifted out when no TX byte is staged.
- `RXFIFO_DEPTH`, 4, RX FIFO entries; power of two; used only with `SPITGT_RXFIFO_EN`.

Ports:
- `clk`  in  1  system clock; all logic is on its rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `spi_sck`  in  1  SPI clock; asynchronous to `clk`.
- `spi_mosi`  in  1  host-to-target data.
- `spi_ssel_n`  in  1  chip select, active-low.
- `spi_miso`  out  1  target-to-host data.
- `spi_miso_oe`  out  1  MISO output enable; 1 while selected.
- `txdata`  in  8  byte for the next transfer.
- `txwrite`  in  1  1-cycle strobe; writes `txdata` to the holding register.
- `txempty`  out  1  holding register empty.
- `rxdata`  out  8  oldest received byte.
- `rxvalid`  out  1  `rxdata` holds a valid byte.
- `rxread`  in  1  1-cycle strobe; consumes `rxdata`.
- `overrun`  out  1  sticky flag: a received byte was dropped.
- `overrun_clr`  in  1  clears `overrun`.
- `busy`  out  1  selected with a byte in progress (bit count ≠ 0).

## Operation
- `spi_sck`, `spi_mosi` and `spi_ssel_n` pass through 2-FF synchronizers. Edges are detected by comparing synchronizer stage 2 with a delayed copy.
- States:
  - IDLE: `spi_ssel_n` synchronized high. Bit counter is 0 and `spi_miso_oe` is 0.
  - ACTIVE: entered on the synchronized falling edge of `spi_ssel_n`.
    - On entry, the TX shift register loads the holding register (or `IDLE_BYTE` if empty), `txempty` goes to 1, and `spi_miso_oe` goes to 1.
  - Deselect returns the block to IDLE from any point and discards a partial byte. Partial bytes never reach RX and do not set `overrun`.
- In ACTIVE:
  - Rising SCK: shift the synchronized MOSI into the RX shift register LSB (MSB-first transfer) and increment the 3-bit counter.
  - On the 8th rising edge (counter wraps 7→0), the byte is complete:
    - It is pushed to RX.
    - `load_pending` is set.
  - Falling SCK:
    - If `load_pending` is set: load the TX shift register from the holding register (or `IDLE_BYTE`), set `txempty`=1 and clear `load_pending`.
    - Otherwise: shift the TX register left.
  - `spi_miso` = TX shift register bit 7. It is 1 in IDLE.
- RX push with no space available (`rxvalid`=1 without the FIFO; FIFO full with it): the new byte is dropped, `overrun` is set, and stored data is unchanged.
- Push and `rxread` in the same cycle: both take effect. The pushed byte is never lost.
- `txwrite` when `txempty`=0 overwrites the staged byte.
- `txwrite` in the same cycle as a TX load:
  - The load uses the old holding content.
  - The new byte stays staged and `txempty` is 0.
- `overrun_clr` and a new overrun in the same cycle: `overrun` stays 1.
- `rxread` while `rxvalid`=0 is ignored.

## Timing
- Reset values: `spi_miso`=1, `spi_miso_oe`=0, `txempty`=1, `rxvalid`=0, `rxdata`=0, `overrun`=0, `busy`=0. Reset also clears the shift registers, counter, `load_pending` and synchronizers.
- `rst` asserted mid-byte: the block returns to IDLE on the next edge. If `spi_ssel_n` is still low after reset, a new falling edge is required before ACTIVE is re-entered.
- Pin change to internal action: 3 `clk` edges. `rxvalid` rises 3 cycles after the 8th SCK rising edge at the pin.
- Host requirements:
  - SCK high and low phases ≥ 3 `clk` periods each.
  - MOSI stable ≥ 3 `clk` around SCK rising.
  - `spi_ssel_n` low ≥ 4 `clk` before the first SCK rising edge.
- MISO changes ≤ 3 `clk` after SCK falling or the SSEL falling edge.
- `rxvalid` clears the cycle after `rxread` unless more data is queued.

## Configuration
- `SPITGT_RXFIFO_EN` defined:
  - RX is a `RXFIFO_DEPTH`-entry FIFO with `rxdata` = head.
  - `rxvalid` = not empty; `rxread` pops.
  - Overrun occurs when the FIFO is full.
- `SPITGT_RXFIFO_EN` undefined:
  - RX is a single holding register.
  - Overrun occurs when `rxvalid`=1 at push.
  - `RXFIFO_DEPTH` is ignored.

## Test plan
- Reset, then stage 8'hA5. Host sends 8'h55 at SCK = clk/8 → `rxdata`=8'h55 and `rxvalid`=1 three cycles after the 8th rising edge; host receives 8'hA5; `txempty`=1.
- Two back-to-back bytes with nothing staged → host receives 8'hFF, 8'hFF. `txwrite` of 8'h3C during byte 1 → byte 2 returns 8'h3C.
- Three bytes with no `rxread`:
  - Without FIFO: first byte kept, `overrun`=1.
  - With FIFO: all three are read back in order and `overrun`=0.
  - Then `overrun_clr` → `overrun`=0.
- Deselect after 5 bits, then a full byte 8'h81 → only 8'h81 is received, `busy`=0 between, and no overrun.
- `rst` pulsed mid-byte with SSEL low → all outputs at reset values; no byte received until SSEL toggles.
- Push coincident with `rxread` while full (non-FIFO) → new byte visible, `overrun`=0.

Source files
------------

// File: rtl/spi_target.sv
// Mode-0 SPI target, pins oversampled on clk, one-byte TX holding register.
// Define SPITGT_RXFIFO_EN for an RXFIFO_DEPTH-entry RX FIFO instead of a single RX register.
module spi_target #(
    parameter logic [7:0] IDLE_BYTE    = 8'hFF,
    parameter int         RXFIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       spi_sck,
    input  logic       spi_mosi,
    input  logic       spi_ssel_n,
    output logic       spi_miso,
    output logic       spi_miso_oe,
    input  logic [7:0] txdata,
    input  logic       txwrite,
    output logic       txempty,
    output logic [7:0] rxdata,
    output logic       rxvalid,
    input  logic       rxread,
    output logic       overrun,
    input  logic       overrun_clr,
    output logic       busy
);

    typedef enum logic {
        S_IDLE,
        S_ACTIVE
    } state_t;

    state_t state, state_n;

    logic sck_s1, sck_s2, sck_d;
    logic mosi_s1, mosi_s2;
    logic ssel_s1, ssel_s2, ssel_d;

    logic       sck_rise, sck_fall, ssel_fall;
    logic       entry, leave, rx_shift, tx_fall;
    logic [2:0] cnt;
    logic [6:0] rxsr;
    logic [7:0] txsr;
    logic       load_pending;
    logic [7:0] tx_hold;
    logic [7:0] tx_next;
    logic [7:0] rx_byte;
    logic       tx_load;
    logic       push, accept, drop;

    // Two-flop synchronizers plus a delayed copy for edge detection.
    // Cleared to 0 so a select held low through reset never looks like a new edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            sck_s1  <= 1'b0;
            sck_s2  <= 1'b0;
            sck_d   <= 1'b0;
            mosi_s1 <= 1'b0;
            mosi_s2 <= 1'b0;
            ssel_s1 <= 1'b0;
            ssel_s2 <= 1'b0;
            ssel_d  <= 1'b0;
        end else begin
            sck_s1  <= spi_sck;
            sck_s2  <= sck_s1;
            sck_d   <= sck_s2;
            mosi_s1 <= spi_mosi;
            mosi_s2 <= mosi_s1;
            ssel_s1 <= spi_ssel_n;
            ssel_s2 <= ssel_s1;
            ssel_d  <= ssel_s2;
        end
    end

    assign sck_rise  = sck_s2 & ~sck_d;
    assign sck_fall  = ~sck_s2 & sck_d;
    assign ssel_fall = ~ssel_s2 & ssel_d;

    assign rx_byte = {rxsr, mosi_s2};
    assign tx_next = txempty ? IDLE_BYTE : tx_hold;
    assign push    = rx_shift & (cnt == 3'd7);
    assign tx_load = entry | (tx_fall & load_pending);

    // Select state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next state and per-cycle datapath strobes.
    always_comb begin
        state_n  = state;
        entry    = 1'b0;
        leave    = 1'b0;
        rx_shift = 1'b0;
        tx_fall  = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (ssel_fall) begin
                    state_n = S_ACTIVE;
                    entry   = 1'b1;
                end
            end
            S_ACTIVE: begin
                if (ssel_s2) begin
                    state_n = S_IDLE;
                    leave   = 1'b1;
                end else begin
                    rx_shift = sck_rise;
                    tx_fall  = sck_fall;
                end
            end
        endcase
    end

    // Bit counter and shift registers; deselect drops any partial byte.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt          <= 3'd0;
            rxsr         <= 7'd0;
            txsr         <= 8'd0;
            load_pending <= 1'b0;
        end else if (leave) begin
            cnt          <= 3'd0;
            load_pending <= 1'b0;
        end else begin
            if (entry) begin
                txsr <= tx_next;
            end
            if (rx_shift) begin
                rxsr <= rx_byte[6:0];
                cnt  <= cnt + 3'd1;
                if (cnt == 3'd7) begin
                    load_pending <= 1'b1;
                end
            end
            if (tx_fall) begin
                if (load_pending) begin
                    txsr         <= tx_next;
                    load_pending <= 1'b0;
                end else begin
                    txsr <= {txsr[6:0], 1'b0};
                end
            end
        end
    end

    // TX holding register; a write in the load cycle stays staged.
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_hold <= 8'd0;
            txempty <= 1'b1;
        end else begin
            if (tx_load) begin
                txempty <= 1'b1;
            end
            if (txwrite) begin
                tx_hold <= txdata;
                txempty <= 1'b0;
            end
        end
    end

`ifdef SPITGT_RXFIFO_EN
    localparam int AW = $clog2(RXFIFO_DEPTH);

    logic [7:0]  mem [RXFIFO_DEPTH];
    logic [AW:0] wp, rp;
    logic        empty, full, pop;

    assign empty  = (wp == rp);
    assign full   = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
    assign pop    = rxread & ~empty;
    assign accept = push & (~full | pop);
    assign drop   = push & ~accept;

    // RX FIFO storage and pointers; a pop frees room for a same-cycle push.
    always_ff @(posedge clk) begin
        if (rst) begin
            wp <= '0;
            rp <= '0;
            for (int i = 0; i < RXFIFO_DEPTH; i++) begin
                mem[i] <= 8'd0;
            end
        end else begin
            if (accept) begin
                mem[wp[AW-1:0]] <= rx_byte;
                wp              <= wp + 1'b1;
            end
            if (pop) begin
                rp <= rp + 1'b1;
            end
        end
    end

    assign rxdata  = mem[rp[AW-1:0]];
    assign rxvalid = ~empty;
`else
    logic [7:0] rx_hold;
    logic       rx_full;

    assign accept = push & (~rx_full | rxread);
    assign drop   = push & ~accept;

    // Single RX register; a read in the push cycle makes room.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_hold <= 8'd0;
            rx_full <= 1'b0;
        end else if (accept) begin
            rx_hold <= rx_byte;
            rx_full <= 1'b1;
        end else if (rxread) begin
            rx_full <= 1'b0;
        end
    end

    assign rxdata  = rx_hold;
    assign rxvalid = rx_full;
`endif

    // Sticky overrun; a new drop wins over a clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            overrun <= 1'b0;
        end else begin
            if (overrun_clr) begin
                overrun <= 1'b0;
            end
            if (drop) begin
                overrun <= 1'b1;
            end
        end
    end

    assign spi_miso    = (state == S_ACTIVE) ? txsr[7] : 1'b1;
    assign spi_miso_oe = (state == S_ACTIVE);
    assign busy        = (state == S_ACTIVE) && (cnt != 3'd0);

endmodule
